// File: rtl/hazard_unit_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
// Pipeline register enables and flushes flow back to the datapath.
interface hazard_unit_if #(
    parameter int CNT_WIDTH = 32
);
    logic [4:0]           rs1_address_id_i;
    logic [4:0]           rs2_address_id_i;
    logic                 rs1_used_id_i;
    logic                 rs2_used_id_i;
    logic                 branch_id_i;
    logic                 branch_taken_id_i;
    logic                 reg_write_ex_i;
    logic                 mem_to_reg_ex_i;
    logic [4:0]           rd_address_ex_i;
    logic                 mem_to_reg_mem_i;
    logic [4:0]           rd_address_mem_i;
    logic                 div_start_ex_i;
    logic                 div_done_i;
    logic                 pc_en_o;
    logic                 if_id_en_o;
    logic                 if_id_flush_o;
    logic                 id_ex_en_o;
    logic                 id_ex_flush_o;
    logic                 ex_mem_flush_o;
    logic                 stall_o;
    logic [CNT_WIDTH-1:0] stall_cnt_o;

    modport master (
        output rs1_address_id_i, rs2_address_id_i, rs1_used_id_i, rs2_used_id_i,
               branch_id_i, branch_taken_id_i, reg_write_ex_i, mem_to_reg_ex_i,
               rd_address_ex_i, mem_to_reg_mem_i, rd_address_mem_i,
               div_start_ex_i, div_done_i,
        input  pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
               ex_mem_flush_o, stall_o, stall_cnt_o
    );

    modport slave (
        input  rs1_address_id_i, rs2_address_id_i, rs1_used_id_i, rs2_used_id_i,
               branch_id_i, branch_taken_id_i, reg_write_ex_i, mem_to_reg_ex_i,
               rd_address_ex_i, mem_to_reg_mem_i, rd_address_mem_i,
               div_start_ex_i, div_done_i,
        output pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
               ex_mem_flush_o, stall_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use, ID-branch operand and divider stalls.
// Optional stall performance counter enabled by HAZARD_PERF_CNT_EN.
module hazard_unit #(
    parameter int CNT_WIDTH = 32
) (
    input logic          clk,
    input logic          reset,
    hazard_unit_if.slave hz
);
    typedef enum logic {IDLE, DIV_BUSY} state_e;

    state_e state_q, state_d;
    logic   rs1_match_ex, rs2_match_ex, rs1_match_mem, rs2_match_mem;
    logic   match_ex, match_mem;
    logic   load_use, branch_haz, hz_stall, div_stall;

    // x0 is hardwired zero, so a write to it never creates a dependency
    assign rs1_match_ex  = hz.rs1_used_id_i && (hz.rd_address_ex_i != 5'd0)
                           && (hz.rd_address_ex_i == hz.rs1_address_id_i);
    assign rs2_match_ex  = hz.rs2_used_id_i && (hz.rd_address_ex_i != 5'd0)
                           && (hz.rd_address_ex_i == hz.rs2_address_id_i);
    assign rs1_match_mem = hz.rs1_used_id_i && (hz.rd_address_mem_i != 5'd0)
                           && (hz.rd_address_mem_i == hz.rs1_address_id_i);
    assign rs2_match_mem = hz.rs2_used_id_i && (hz.rd_address_mem_i != 5'd0)
                           && (hz.rd_address_mem_i == hz.rs2_address_id_i);
    assign match_ex  = rs1_match_ex | rs2_match_ex;
    assign match_mem = rs1_match_mem | rs2_match_mem;

    assign load_use   = hz.mem_to_reg_ex_i & match_ex;
    assign branch_haz = hz.branch_id_i & ((hz.reg_write_ex_i & match_ex) |
                                          (hz.mem_to_reg_mem_i & match_mem));
    assign hz_stall   = load_use | branch_haz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (hz.div_start_ex_i && !hz.div_done_i) state_d = DIV_BUSY;
            DIV_BUSY: if (hz.div_done_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        div_stall         = (state_q == DIV_BUSY) ? !hz.div_done_i
                                                  : (hz.div_start_ex_i && !hz.div_done_i);
        hz.pc_en_o        = 1'b1;
        hz.if_id_en_o     = 1'b1;
        hz.if_id_flush_o  = 1'b0;
        hz.id_ex_en_o     = 1'b1;
        hz.id_ex_flush_o  = 1'b0;
        hz.ex_mem_flush_o = 1'b0;
        hz.stall_o        = div_stall | hz_stall;
        if (reset) begin
            hz.pc_en_o    = 1'b0;
            hz.if_id_en_o = 1'b0;
            hz.id_ex_en_o = 1'b0;
            hz.stall_o    = 1'b0;
        end else if (div_stall) begin
            // freeze front end; EX result is not ready so bubble EX/MEM
            hz.pc_en_o        = 1'b0;
            hz.if_id_en_o     = 1'b0;
            hz.id_ex_en_o     = 1'b0;
            hz.ex_mem_flush_o = 1'b1;
        end else if (hz_stall) begin
            hz.pc_en_o       = 1'b0;
            hz.if_id_en_o    = 1'b0;
            hz.id_ex_flush_o = 1'b1;
        end else begin
            hz.if_id_flush_o = hz.branch_taken_id_i;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    assign cnt_d = (hz.stall_o && (cnt_q != {CNT_WIDTH{1'b1}}))
                   ? cnt_q + CNT_WIDTH'(1) : cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign hz.stall_cnt_o = cnt_q;
`else
    assign hz.stall_cnt_o = {CNT_WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; outputs are checked #1 after the
// falling edge where inputs are applied, state advances on the next rising edge.
module tb_hazard_unit;
    localparam int CW = 32;
    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush, stall}
    localparam logic [6:0] RUN   = 7'b1101000;
    localparam logic [6:0] HZ    = 7'b0001101;
    localparam logic [6:0] DIV   = 7'b0000011;
    localparam logic [6:0] TAKEN = 7'b1111000;
    localparam logic [6:0] ZERO  = 7'b0000000;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [6:0] obs;

    hazard_unit_if #(.CNT_WIDTH(CW)) hz ();

    hazard_unit #(.CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    assign obs = {hz.pc_en_o, hz.if_id_en_o, hz.if_id_flush_o, hz.id_ex_en_o,
                  hz.id_ex_flush_o, hz.ex_mem_flush_o, hz.stall_o};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply one cycle of inputs just after the falling edge, then settle.
    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic br, input logic tk, input logic rwex,
                         input logic ldex, input logic [4:0] rdex, input logic ldmem,
                         input logic [4:0] rdmem, input logic ds, input logic dd);
        @(negedge clk);
        hz.rs1_address_id_i  = rs1;
        hz.rs2_address_id_i  = rs2;
        hz.rs1_used_id_i     = u1;
        hz.rs2_used_id_i     = u2;
        hz.branch_id_i       = br;
        hz.branch_taken_id_i = tk;
        hz.reg_write_ex_i    = rwex;
        hz.mem_to_reg_ex_i   = ldex;
        hz.rd_address_ex_i   = rdex;
        hz.mem_to_reg_mem_i  = ldmem;
        hz.rd_address_mem_i  = rdmem;
        hz.div_start_ex_i    = ds;
        hz.div_done_i        = dd;
        #1;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        // hazard and divide both requested, reset must still hold everything low
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 1'b0);
        total++;
        if (obs !== ZERO) begin
            bad++;
            $display("FAIL reset_outputs: got %b want %b", obs, ZERO);
        end
        total++;
        if (hz.stall_cnt_o !== '0) begin
            bad++;
            $display("FAIL reset_counter: got %0d want 0", hz.stall_cnt_o);
        end
        idle();
        reset = 1'b0;
        #1;
        total++;
        if (obs !== RUN) begin
            bad++;
            $display("FAIL reset_release: got %b want %b", obs, RUN);
        end
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        // lw x5 in EX, add reading rs2=x5 in ID
        drive(5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
        total++;
        if (obs !== HZ) begin
            bad++;
            $display("FAIL load_use_stall: got %b want %b", obs, HZ);
        end
        // load now in MEM, bubble in EX: forwarding covers it
        drive(5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
        total++;
        if (obs !== RUN) begin
            bad++;
            $display("FAIL load_use_release: got %b want %b", obs, RUN);
        end
        // load rd matches rs2 but rs2 unused
        drive(5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
        total++;
        if (obs !== RUN) begin
            bad++;
            $display("FAIL load_use_unused_rs: got %b want %b", obs, RUN);
        end
        // non-branch ALU producer in EX is forwarded, no stall
        drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0);
        total++;
        if (obs !== RUN) begin
            bad++;
            $display("FAIL alu_no_stall: got %b want %b", obs, RUN);
        end
        $display("test_load_use done");
    endtask

    task automatic test_x0();
        drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        total++;
        if (hz.stall_o !== 1'b0) begin
            bad++;
            $display("FAIL x0_no_hazard: got %b want 0", hz.stall_o);
        end
        $display("test_x0 done");
    endtask

    task automatic test_branch();
        // beq rs1=x7 in ID, lw x7 in EX; taken asserted but must be ignored while stalled
        drive(5'd7, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0);
        total++;
        if (obs !== HZ) begin
            bad++;
            $display("FAIL branch_load_stall1: got %b want %b", obs, HZ);
        end
        // load moved to MEM, bubble in EX
        drive(5'd7, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0);
        total++;
        if (obs !== HZ) begin
            bad++;
            $display("FAIL branch_load_stall2: got %b want %b", obs, HZ);
        end
        drive(5'd7, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        total++;
        if (obs !== TAKEN) begin
            bad++;
            $display("FAIL branch_taken_flush: got %b want %b", obs, TAKEN);
        end
        idle();
        total++;
        if (obs !== RUN) begin
            bad++;
            $display("FAIL branch_flush_one_cycle: got %b want %b", obs, RUN);
        end
        // bne rs2=x9, ALU writes x9 in EX: one bubble
        drive(5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0);
        total++;
        if (obs !== HZ) begin
            bad++;
            $display("FAIL branch_alu_stall: got %b want %b", obs, HZ);
        end
        // ALU result in MEM (not a load): forwarded, no second bubble
        drive(5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0);
        total++;
        if (obs !== RUN) begin
            bad++;
            $display("FAIL branch_alu_release: got %b want %b", obs, RUN);
        end
        $display("test_branch done");
    endtask

    task automatic test_divide();
        logic [CW-1:0] exp_cnt;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        for (int c = 0; c < 33; c++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 5'd0, 1'b1, 1'b0);
            total++;
            if (obs !== DIV) begin
                bad++;
                $display("FAIL div_stall_c%0d: got %b want %b", c, obs, DIV);
            end
        end
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 5'd0, 1'b1, 1'b1);
        total++;
        if (obs !== RUN) begin
            bad++;
            $display("FAIL div_done_release: got %b want %b", obs, RUN);
        end
        idle();
        total++;
        if (obs !== RUN) begin
            bad++;
            $display("FAIL div_back_idle: got %b want %b", obs, RUN);
        end
`ifdef HAZARD_PERF_CNT_EN
        exp_cnt = 32'd33;
`else
        exp_cnt = 32'd0;
`endif
        total++;
        if (hz.stall_cnt_o !== exp_cnt) begin
            bad++;
            $display("FAIL div_stall_count: got %0d want %0d", hz.stall_cnt_o, exp_cnt);
        end
        // start and done together in IDLE: no stall, no state change
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        total++;
        if (obs !== RUN) begin
            bad++;
            $display("FAIL div_single_cycle: got %b want %b", obs, RUN);
        end
        idle();
        total++;
        if (obs !== RUN) begin
            bad++;
            $display("FAIL div_single_no_state: got %b want %b", obs, RUN);
        end
        $display("test_divide done");
    endtask

    task automatic test_priority_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 5'd0, 1'b1, 1'b0);
        // start dropped while busy: still stalled because it is ignored in DIV_BUSY
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        total++;
        if (obs !== DIV) begin
            bad++;
            $display("FAIL div_busy_hold: got %b want %b", obs, DIV);
        end
        // load-use hazard on top of a busy divider
        drive(5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 1'b1, 1'b0);
        total++;
        if (obs !== DIV) begin
            bad++;
            $display("FAIL priority_div_over_hz: got %b want %b", obs, DIV);
        end
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 5'd0, 1'b1, 1'b0);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 5'd0, 1'b1, 1'b0);
        total++;
        if (obs !== DIV) begin
            bad++;
            $display("FAIL div_cycle5_pre_reset: got %b want %b", obs, DIV);
        end
        reset = 1'b1;
        #1;
        total++;
        if ((obs !== ZERO) || (hz.stall_cnt_o !== '0)) begin
            bad++;
            $display("FAIL reset_mid_div: got %b cnt=%0d want %b cnt=0", obs, hz.stall_cnt_o, ZERO);
        end
        idle();
        reset = 1'b0;
        #1;
        total++;
        if (obs !== RUN) begin
            bad++;
            $display("FAIL reset_forces_idle: got %b want %b", obs, RUN);
        end
        $display("test_priority_reset done");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        test_reset();
        test_load_use();
        test_x0();
        test_branch();
        test_divide();
        test_priority_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the RV32IMA core. It sits upstream of the forwarding unit and owns the pipeline register enables and flushes (PC, IF/ID, ID/EX, EX/MEM). It handles three cases the forwarding paths cannot cover:
- load-use stalls;
- operand stalls for branches resolved in ID;
- multi-cycle M-extension divide/remainder stalls, tracked by a small FSM.

## Interface
Parameters:
- CNT_WIDTH, 32, width of the stall performance counter (used only with HAZARD_PERF_CNT_EN).

Ports (all single-cycle-valid, sampled on rising clk):
- clk  in  1  core clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- rs1_address_id_i  in  5  rs1 of the instruction in ID.
- rs2_address_id_i  in  5  rs2 of the instruction in ID.
- rs1_used_id_i  in  1  ID instruction reads rs1.
- rs2_used_id_i  in  1  ID instruction reads rs2.
- branch_id_i  in  1  ID instruction is a conditional branch or JALR (compares/uses registers in ID).
- branch_taken_id_i  in  1  branch/jump in ID resolves taken this cycle.
- reg_write_ex_i  in  1  EX instruction writes rd.
- mem_to_reg_ex_i  in  1  EX instruction is a load.
- rd_address_ex_i  in  5  rd of the EX instruction.
- mem_to_reg_mem_i  in  1  MEM instruction is a load.
- rd_address_mem_i  in  5  rd of the MEM instruction.
- div_start_ex_i  in  1  EX holds a DIV/DIVU/REM/REMU; held high while that instruction stays in EX.
- div_done_i  in  1  divider result valid this cycle.
- pc_en_o  out  1  PC update enable.
- if_id_en_o  out  1  IF/ID register enable.
- if_id_flush_o  out  1  IF/ID register clear.
- id_ex_en_o  out  1  ID/EX register enable.
- id_ex_flush_o  out  1  insert a bubble into ID/EX.
- ex_mem_flush_o  out  1  insert a bubble into EX/MEM.
- stall_o  out  1  any stall active.
- stall_cnt_o  out  CNT_WIDTH  stall cycle count.

## Operation
- A match exists when `rd != 0`, `rd == rsN_address_id_i`, and `rsN_used_id_i = 1`, for rs1 or rs2.
- **Load-use hazard:** `mem_to_reg_ex_i` and a match against `rd_address_ex_i`.
- **Branch hazards:** when `branch_id_i = 1`, any of the following:
  - a match against EX with `reg_write_ex_i = 1` (covers both ALU ops and loads in EX);
  - a match against MEM with `mem_to_reg_mem_i = 1`.
  - Net effect: an ALU producer costs 1 bubble, a load producer costs 2.
- `hz_stall` is asserted when either hazard above is present.
  - Outputs: `pc_en_o = 0`, `if_id_en_o = 0`, `id_ex_flush_o = 1`, `id_ex_en_o = 1`.
- **Divider FSM** (registered state):
  - States: `IDLE`, `DIV_BUSY`.
  - `IDLE` → `DIV_BUSY` when `div_start_ex_i = 1` and `div_done_i = 0`.
  - `DIV_BUSY` → `IDLE` when `div_done_i = 1`.
  - `div_start_ex_i` is ignored while in `DIV_BUSY`.
  - `div_stall = div_start_ex_i & !div_done_i` when in `IDLE`; `div_stall = !div_done_i` when in `DIV_BUSY`.
- **Priority:** `div_stall` overrides `hz_stall`.
  - During `div_stall`: `pc_en_o = 0`, `if_id_en_o = 0`, `id_ex_en_o = 0`, `id_ex_flush_o = 0`, `ex_mem_flush_o = 1`.
- **Taken branch:** `if_id_flush_o = branch_taken_id_i & !hz_stall & !div_stall`. `pc_en_o` stays 1 in that cycle.
- `branch_taken_id_i` asserted while the branch is stalled is ignored.
- **No stall:** all enables are 1 and all flushes are 0.
- `stall_o = hz_stall | div_stall`.

## Timing
- All outputs are combinational from the current inputs and FSM state. Zero-cycle latency.
- While `reset = 1`:
  - FSM = `IDLE`, `stall_cnt_o = 0`;
  - all enables 0, all flushes 0, `stall_o = 0`.
- Reset asserted mid-divide forces `IDLE` immediately (asynchronously). After deassertion the FSM waits for a new `div_start_ex_i`.
- **Divide cycle-level behaviour:** with start at cycle 0 and done at cycle k:
  - `div_stall` is high for cycles 0..k-1;
  - enables return to 1 in cycle k, so ID/EX captures the next instruction at the end of cycle k.
- **Single-cycle divide:** if `div_start_ex_i` and `div_done_i` are both high in `IDLE`, there is no stall and no state change.
- Load-use and branch stalls re-evaluate every cycle. A 2-bubble branch stall appears as two consecutive stalled cycles as the load advances EX → MEM.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cnt_o` increments by 1 on each rising clk where `stall_o = 1`;
  - it saturates at all-ones and clears only on reset.
- `HAZARD_PERF_CNT_EN` not defined: no counter register; `stall_cnt_o` is tied to 0. The port list is unchanged.

## Test plan
- **Load-use:** load `x5` in EX, ID `add` reading rs2 = 5 → one cycle of `pc_en_o = 0`, `if_id_en_o = 0`, `id_ex_flush_o = 1`. Next cycle (load in MEM) → no stall.
- **Branch after load:** `beq` in ID with rs1 = 7, load `x7` in EX → stall 2 consecutive cycles, then `branch_taken_id_i = 1` → `if_id_flush_o = 1` for exactly 1 cycle.
- **x0 never hazards:** `rd = 0` load in EX, `rs1 = 0` used in ID → `stall_o = 0`.
- **Divide:** `div_start_ex_i = 1` at cycle 0, `div_done_i` at cycle 33 → `ex_mem_flush_o = 1` and `id_ex_en_o = 0` for cycles 0..32; all enables are 1 at cycle 33. With `HAZARD_PERF_CNT_EN` defined, `stall_cnt_o = 33` afterwards.
- **Priority and reset:** divider busy plus load-use hazard together → `id_ex_flush_o = 0`, `ex_mem_flush_o = 1`. Assert `reset` at cycle 5 of the divide → FSM returns to `IDLE` and all outputs are 0 immediately.
